// File: rtl/ram_bist_pkg.sv
// Shared defaults and FSM state encoding for the RAM BIST master.
package ram_bist_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 8;
    localparam int RD_LAT_DEF = 1;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_WRITE = 3'd1;
    localparam logic [2:0] ST_READ  = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

endpackage

// File: rtl/ram_bist_cmp.sv
// Read-data checker: delays expected data/address by RD_LAT cycles to line up
// with mem_dataout, counts mismatches (saturating) and latches the first one.
module ram_bist_cmp
    import ram_bist_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int RD_LAT = RD_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              rd_vld,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_exp,
    input  logic [DATA_W-1:0] dataout,
    output logic [7:0]        err_count,
    output logic [7:0]        err_next,
    output logic [ADDR_W-1:0] first_err_addr
);

    logic [RD_LAT:1]             vld_pipe;
    logic [RD_LAT:1][ADDR_W-1:0] addr_pipe;
    logic [RD_LAT:1][DATA_W-1:0] exp_pipe;
    logic                        hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[1] <= rd_vld;
            for (int k = 2; k <= RD_LAT; k++) vld_pipe[k] <= vld_pipe[k-1];
        end
    end

    always_ff @(posedge clk) begin
        addr_pipe[1] <= rd_addr;
        exp_pipe[1]  <= rd_exp;
        for (int k = 2; k <= RD_LAT; k++) begin
            addr_pipe[k] <= addr_pipe[k-1];
            exp_pipe[k]  <= exp_pipe[k-1];
        end
    end

    assign hit = vld_pipe[RD_LAT] && (dataout != exp_pipe[RD_LAT]);

    // err_next is exported so the FSM can settle pass in the same edge as the last compare
    always_comb begin
        err_next = err_count;
        if (clr)
            err_next = '0;
        else if (hit && err_count != 8'hFF)
            err_next = err_count + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_count      <= '0;
            first_err_addr <= '0;
        end else begin
            err_count <= err_next;
            if (clr)
                first_err_addr <= '0;
            else if (hit && err_count == 8'd0)
                first_err_addr <= addr_pipe[RD_LAT];
        end
    end

endmodule

// File: rtl/ram_bist_master.sv
// RAM BIST master: writes addr^seed over a wrapping address window, reads it
// back, and reports a pass/fail verdict with error count and first bad address.
module ram_bist_master
    import ram_bist_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int RD_LAT = RD_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] len,
    input  logic [DATA_W-1:0] seed,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_datain,
    output logic              mem_wr,
    output logic              mem_read,
    output logic              mem_chipselect,
    input  logic [DATA_W-1:0] mem_dataout,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [7:0]        err_count,
    output logic [ADDR_W-1:0] first_err_addr
);

    logic [2:0]        state;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] len_q;
    logic [ADDR_W-1:0] base_q;
    logic [DATA_W-1:0] seed_q;
    logic [ADDR_W-1:0] next_addr;
    logic [7:0]        err_next;
    logic              start_ok;

    assign start_ok       = (state == ST_IDLE) && start;
    assign next_addr      = mem_addr + ADDR_W'(1);
    assign mem_wr         = (state == ST_WRITE);
    assign mem_read       = (state == ST_READ);
    assign mem_chipselect = mem_wr | mem_read;
    assign busy           = (state != ST_IDLE);
    assign done           = (state == ST_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            len_q      <= '0;
            base_q     <= '0;
            seed_q     <= '0;
            mem_addr   <= '0;
            mem_datain <= '0;
            pass       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (start) begin
                    state      <= ST_WRITE;
                    cnt        <= '0;
                    len_q      <= len;
                    base_q     <= base_addr;
                    seed_q     <= seed;
                    mem_addr   <= base_addr;
                    mem_datain <= DATA_W'(base_addr) ^ seed;
                    pass       <= 1'b0;
                end
                ST_WRITE: begin
                    if (cnt == len_q) begin
                        // rewind for the read pass; datain keeps the last written word
                        state    <= ST_READ;
                        cnt      <= '0;
                        mem_addr <= base_q;
                    end else begin
                        cnt        <= cnt + ADDR_W'(1);
                        mem_addr   <= next_addr;
                        mem_datain <= DATA_W'(next_addr) ^ seed_q;
                    end
                end
                ST_READ: begin
                    if (cnt == len_q) begin
                        state <= ST_DRAIN;
                        cnt   <= '0;
                    end else begin
                        cnt      <= cnt + ADDR_W'(1);
                        mem_addr <= next_addr;
                    end
                end
                ST_DRAIN: begin
                    if (cnt == ADDR_W'(RD_LAT - 1)) begin
                        state <= ST_DONE;
                        pass  <= (err_next == 8'd0);
                    end else begin
                        cnt <= cnt + ADDR_W'(1);
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    ram_bist_cmp #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .RD_LAT(RD_LAT)
    ) u_cmp (
        .clk           (clk),
        .rst           (rst),
        .clr           (start_ok),
        .rd_vld        (mem_read),
        .rd_addr       (mem_addr),
        .rd_exp        (DATA_W'(mem_addr) ^ seed_q),
        .dataout       (mem_dataout),
        .err_count     (err_count),
        .err_next      (err_next),
        .first_err_addr(first_err_addr)
    );

endmodule

// File: tb/tb_ram_bist_master.sv
// Bench for ram_bist_master: 1024x8 RAM model with selectable read faults,
// cycle-exact strobe timeline checks and a reference result model.
module tb_ram_bist_master;

    localparam int AW = 10;
    localparam int DW = 8;
    localparam int RL = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW-1:0] len = '0;
    logic [DW-1:0] seed = '0;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_datain;
    logic          mem_wr, mem_read, mem_chipselect;
    logic [DW-1:0] mem_dataout;
    logic          busy, done, pass;
    logic [7:0]    err_count;
    logic [AW-1:0] first_err_addr;

    int n_cmp = 0;
    int n_bad = 0;
    int fault_mode = 0;  // 0 good, 1 bit3 stuck at 0, 2 reads all zero

    always #5 clk = ~clk;

    ram_bist_master #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len), .seed(seed),
        .mem_addr(mem_addr), .mem_datain(mem_datain), .mem_wr(mem_wr), .mem_read(mem_read),
        .mem_chipselect(mem_chipselect), .mem_dataout(mem_dataout), .busy(busy), .done(done),
        .pass(pass), .err_count(err_count), .first_err_addr(first_err_addr)
    );

    logic [DW-1:0] ram [1024];
    logic [DW-1:0] rdata = '0;

    always @(posedge clk) begin
        if (mem_chipselect && mem_wr) ram[mem_addr] <= mem_datain;
        if (mem_chipselect && mem_read) rdata <= ram[mem_addr];
    end

    always_comb begin
        mem_dataout = rdata;
        if (fault_mode == 1) mem_dataout = rdata & 8'hF7;
        else if (fault_mode == 2) mem_dataout = '0;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Result of a test derived directly from the pattern rule and the fault type
    function automatic void ref_model(int b, int l, int s, int mode,
                                      output int err, output int first, output bit ok);
        err = 0;
        first = 0;
        for (int i = 0; i <= l; i++) begin
            int a = (b + i) % 1024;
            int p = (a % 256) ^ s;
            int r = (mode == 1) ? (p & 'hF7) : (mode == 2) ? 0 : p;
            if (r != p) begin
                if (err == 0) first = a;
                if (err < 255) err++;
            end
        end
        ok = (err == 0);
    endfunction

    task automatic run_test(int b, int l, int s, int mode, bit restart,
                            int exp_err, int exp_first, bit exp_pass);
        int n = l + 1;
        int last = 2 * n + RL + 1;
        int dones = 0;
        fault_mode = mode;
        step();
        start = 1'b1;
        base_addr = AW'(b);
        len = AW'(l);
        seed = DW'(s);
        for (int k = 1; k <= last + 3; k++) begin
            bit e_wr, e_rd;
            int ea;
            step();
            start = 1'b0;
            e_wr = (k <= n);
            e_rd = (k > n) && (k <= 2 * n);
            if (e_wr) ea = (b + k - 1) % 1024;
            else if (e_rd) ea = (b + k - n - 1) % 1024;
            else ea = (b + l) % 1024;
            chk("strobes{wr,rd,cs,busy,done}",
                32'({mem_wr, mem_read, mem_chipselect, busy, done}),
                32'({e_wr, e_rd, e_wr | e_rd, k <= last, k == last}));
            chk("mem_addr", 32'(mem_addr), 32'(ea));
            if (!e_rd) chk("mem_datain", 32'(mem_datain), 32'((ea % 256) ^ s));
            if (done) dones++;
            if (k == 1) chk("clear_on_start", 32'({pass, err_count, first_err_addr}), 32'(0));
            if (k >= last) begin
                chk("err_count", 32'(err_count), 32'(exp_err));
                chk("first_err_addr", 32'(first_err_addr), 32'(exp_first));
                chk("pass", 32'(pass), 32'(exp_pass));
            end
            if (restart && (k == n + 1 || k == last)) start = 1'b1;
        end
        chk("done_pulses", 32'(dones), 32'(1));
    endtask

    typedef struct {
        int base; int len; int seed; int mode; bit restart;
        int exp_err; int exp_first; bit exp_pass;
    } vec_t;

    initial begin
        vec_t vecs[5];
        int rb, rlen, rs, rm, re, rf;
        bit rp;
        int dones;

        vecs[0] = '{0,    9,    'h00, 0, 1'b0, 0,   0, 1'b1};
        vecs[1] = '{1020, 7,    'hA5, 0, 1'b0, 0,   0, 1'b1};
        vecs[2] = '{0,    15,   'h00, 1, 1'b0, 8,   8, 1'b0};
        vecs[3] = '{0,    1023, 'hFF, 2, 1'b0, 255, 0, 1'b0};
        vecs[4] = '{5,    4,    'h3C, 0, 1'b1, 0,   0, 1'b1};

        step();
        step();
        chk("reset_state", 32'({mem_wr, mem_read, mem_chipselect, busy, done, pass}), 32'(0));
        chk("reset_regs", 32'({err_count, first_err_addr, mem_addr}), 32'(0));
        chk("reset_datain", 32'(mem_datain), 32'(0));
        rst = 1'b0;

        foreach (vecs[i])
            run_test(vecs[i].base, vecs[i].len, vecs[i].seed, vecs[i].mode, vecs[i].restart,
                     vecs[i].exp_err, vecs[i].exp_first, vecs[i].exp_pass);

        // Abort a running test with reset, then confirm a clean restart
        fault_mode = 0;
        step();
        start = 1'b1; base_addr = AW'(0); len = AW'(9); seed = 8'h11;
        for (int k = 1; k <= 5; k++) begin
            step();
            start = 1'b0;
        end
        chk("pre_reset_write", 32'(mem_wr), 32'(1));
        rst = 1'b1;
        step();
        chk("abort_strobes", 32'({mem_wr, mem_read, mem_chipselect, busy, done, pass}), 32'(0));
        chk("abort_regs", 32'({err_count, first_err_addr, mem_addr}), 32'(0));
        rst = 1'b0;
        dones = 0;
        for (int k = 0; k < 25; k++) begin
            step();
            if (done || busy || mem_chipselect) dones++;
        end
        chk("aborted_no_activity", 32'(dones), 32'(0));
        run_test(0, 3, 'h11, 0, 1'b0, 0, 0, 1'b1);

        for (int i = 0; i < 12; i++) begin
            rb = int'($urandom_range(0, 1023));
            rlen = int'($urandom_range(0, 40));
            rs = int'($urandom_range(0, 255));
            rm = int'($urandom_range(0, 2));
            ref_model(rb, rlen, rs, rm, re, rf, rp);
            run_test(rb, rlen, rs, rm, 1'($urandom_range(0, 1)), re, rf, rp);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ram_bist_master.md
RAM_BIST_MASTER -- requirements
Module: ram_bist_master

Interface
REQ-001 Parameter ADDR_W, default 10, is the RAM address width.
REQ-002 Parameter DATA_W, default 8, is the RAM data width.
REQ-003 Parameter RD_LAT, default 1, is the number of cycles from a read strobe to valid mem_dataout; legal range is 1..4.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high. The ports are clk (input, 1, rising-edge clock) and rst (input, 1, synchronous active-high reset).
REQ-005 start  input  1  one-cycle request to begin a test; sampled only in IDLE.
REQ-006 base_addr  input  ADDR_W  first address tested; sampled with start.
REQ-007 len  input  ADDR_W  word count minus one (N = len+1, range 1..2^ADDR_W); sampled with start.
REQ-008 seed  input  DATA_W  pattern key; sampled with start.
REQ-009 mem_addr  output  ADDR_W  RAM address.
REQ-010 mem_datain  output  DATA_W  RAM write data.
REQ-011 mem_wr  output  1  RAM write strobe.
REQ-012 mem_read  output  1  RAM read strobe.
REQ-013 mem_chipselect  output  1  RAM select; high whenever mem_wr or mem_read is high.
REQ-014 mem_dataout  input  DATA_W  RAM read data.
REQ-015 busy  output  1  high from the first cycle after an accepted start through the done cycle.
REQ-016 done  output  1  one-cycle completion pulse.
REQ-017 pass  output  1  result of the last test; held until the next accepted start.
REQ-018 err_count  output  8  mismatch count; saturates at 255.
REQ-019 first_err_addr  output  ADDR_W  address of the first mismatch; 0 if there was none.

Function
REQ-020 States SHALL be IDLE, WRITE, READ, DRAIN and DONE, with transitions IDLE->WRITE (start), WRITE->READ (after N writes), READ->DRAIN (after N reads), DRAIN->DONE (after RD_LAT cycles), DONE->IDLE (always).
REQ-021 If start is high in cycle t, writes SHALL occur in cycles t+1..t+N, one word per cycle, with mem_wr=1, mem_chipselect=1, mem_addr=(base_addr+i) mod 2^ADDR_W and mem_datain=(addr[DATA_W-1:0] XOR seed).
REQ-022 Reads SHALL occur in cycles t+N+1..t+2N over the same address sequence, with mem_read=1, mem_chipselect=1 and mem_wr=0.
REQ-023 The read data for a read issued in cycle c SHALL be compared in cycle c+RD_LAT against the expected pattern, which is carried through an RD_LAT-deep delay line.
REQ-024 On each mismatch, err_count SHALL increment and saturate at 255; the first mismatch of a test SHALL capture its address in first_err_addr.
REQ-025 done=1 and pass=(err_count==0) SHALL occur in cycle t+2N+RD_LAT+1; busy SHALL drop in the following cycle.
REQ-026 Outside WRITE and READ, mem_wr, mem_read and mem_chipselect SHALL be 0, and mem_addr and mem_datain SHALL hold their last values.
REQ-027 The address SHALL wrap from 2^ADDR_W-1 to 0 without a gap cycle.
REQ-028 start SHALL be ignored while busy=1, including in the DONE cycle.
REQ-029 An accepted start SHALL clear err_count, first_err_addr and pass in cycle t+1.
REQ-030 mem_wr and mem_read SHALL never be high in the same cycle.

Reset
REQ-031 When rst is high at a clock edge, state SHALL become IDLE and every output SHALL be 0; this applies in any state.
REQ-032 Reset asserted mid-test SHALL abort the test, deassert all strobes in the next cycle and produce no done pulse.
REQ-033 After reset release, a new start SHALL be accepted in the first cycle.

Structure
REQ-034 Package ram_bist_pkg SHALL hold the ADDR_W and DATA_W defaults, the RD_LAT default and the state enumeration.
REQ-035 Sub-module ram_bist_cmp SHALL hold the expected-data and address delay line, the comparator, the saturating err_count and the first_err_addr capture.

Verification
REQ-036 Use a 1024x8 RAM model with RD_LAT=1. Stimulus: base=0, len=9, seed=0x00. Required: writes 0..9 in cycles t+1..t+10, reads in t+11..t+20, done in t+22, pass=1, err_count=0.
REQ-037 Stimulus: base=1020, len=7, seed=0xA5. Required: address sequence 1020,1021,1022,1023,0,1,2,3 in both phases, with no gap cycle at the wrap, and pass=1.
REQ-038 Stimulus: RAM model with bit 3 stuck at 0, base=0, len=15, seed=0x00. Required: err_count=8, first_err_addr=8, pass=0.
REQ-039 Stimulus: RAM model returning all-zero data, len=1023, seed=0xFF. Required: err_count saturates at 255 and pass=0.
REQ-040 Stimulus: rst pulsed in cycle t+5 of a len=9 test, then a new start with len=3. Required: strobes drop after the reset edge, no done for the aborted test, and the second test completes with pass=1.
REQ-041 Stimulus: start re-pulsed during the READ and DONE cycles. Required: both pulses are ignored and there is exactly one done pulse.
